// File: rtl/i2c_temp_sequencer.sv
// Temperature-sensor poll sequencer: drives an 8-step register-read transaction through a
// byte-level I2C engine, latches the 16-bit reading and reports NACK / timeout aborts.
module i2c_temp_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h4B,
  parameter logic [7:0]  PTR_REG        = 8'h00,
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        trigger,
  output logic        busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_last,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        rsp_nack,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        err_nack,
  output logic        err_timeout,
  output logic [7:0]  txn_count
);

  localparam logic [1:0]  OpStart     = 2'd0;
  localparam logic [1:0]  OpStop      = 2'd1;
  localparam logic [1:0]  OpWrite     = 2'd2;
  localparam logic [1:0]  OpRead      = 2'd3;
  localparam logic [31:0] PollReload  = 32'(POLL_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitRsp, StAbortIssue, StAbortWait, StDone
  } state_e;

  state_e      state_q;
  logic [2:0]  step_q;
  logic [31:0] poll_q;
  logic [31:0] tmo_q;
  logic [7:0]  msb_q, lsb_q;
  logic        busy_q, cmd_valid_q, cmd_last_q, temp_valid_q, err_nack_q, err_timeout_q;
  logic [1:0]  cmd_op_q;
  logic [7:0]  cmd_wdata_q, txn_count_q;
  logic [15:0] temp_data_q;

  logic [2:0]  step_next;
  logic [1:0]  nxt_op;
  logic [7:0]  nxt_wdata;
  logic        nxt_last;
  logic        step_is_write, launch, tmo_hit;

  // Command for the step that follows the one just answered
  always_comb begin
    step_next = step_q + 3'd1;
    nxt_op    = OpStart;
    nxt_wdata = 8'h00;
    nxt_last  = 1'b0;
    case (step_next)
      3'd1: begin
        nxt_op    = OpWrite;
        nxt_wdata = {DEV_ADDR, 1'b0};
      end
      3'd2: begin
        nxt_op    = OpWrite;
        nxt_wdata = PTR_REG;
      end
      3'd4: begin
        nxt_op    = OpWrite;
        nxt_wdata = {DEV_ADDR, 1'b1};
      end
      3'd5: nxt_op = OpRead;
      3'd6: begin
        nxt_op   = OpRead;
        nxt_last = 1'b1;
      end
      3'd7:    nxt_op = OpStop;
      default: nxt_op = OpStart;
    endcase
  end

  assign step_is_write = (step_q == 3'd1) || (step_q == 3'd2) || (step_q == 3'd4);
  assign launch        = (state_q == StIdle) && (trigger || (enable && (poll_q == 32'd0)));
  assign tmo_hit       = (tmo_q == TimeoutLast);

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      step_q        <= 3'd0;
      poll_q        <= PollReload;
      tmo_q         <= 32'd0;
      msb_q         <= 8'h00;
      lsb_q         <= 8'h00;
      busy_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= OpStart;
      cmd_wdata_q   <= 8'h00;
      cmd_last_q    <= 1'b0;
      temp_data_q   <= 16'h0000;
      temp_valid_q  <= 1'b0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      txn_count_q   <= 8'h00;
    end else begin
      temp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q     <= StIssue;
            step_q      <= 3'd0;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= OpStart;
            cmd_wdata_q <= 8'h00;
            cmd_last_q  <= 1'b0;
            poll_q      <= PollReload;
          end else if (enable) begin
            poll_q <= poll_q - 32'd1;
          end else begin
            poll_q <= PollReload;
          end
        end
        StIssue, StAbortIssue: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            tmo_q       <= 32'd0;
            state_q     <= (state_q == StIssue) ? StWaitRsp : StAbortWait;
          end
        end
        StWaitRsp: begin
          // A response in the same cycle as the timeout limit takes priority
          if (rsp_valid) begin
            if (step_q == 3'd5) msb_q <= rsp_rdata;
            if (step_q == 3'd6) lsb_q <= rsp_rdata;
            if (step_is_write && rsp_nack) begin
              state_q     <= StAbortIssue;
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= OpStop;
              cmd_wdata_q <= 8'h00;
              cmd_last_q  <= 1'b0;
            end else if (step_q == 3'd7) begin
              state_q <= StDone;
            end else begin
              step_q      <= step_next;
              state_q     <= StIssue;
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= nxt_op;
              cmd_wdata_q <= nxt_wdata;
              cmd_last_q  <= nxt_last;
            end
          end else if (tmo_hit) begin
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StAbortWait: begin
          if (rsp_valid) begin
            err_nack_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (tmo_hit) begin
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StDone: begin
          temp_data_q   <= {msb_q, lsb_q};
          temp_valid_q  <= 1'b1;
          err_nack_q    <= 1'b0;
          err_timeout_q <= 1'b0;
          txn_count_q   <= txn_count_q + 8'd1;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign cmd_last    = cmd_last_q;
  assign temp_data   = temp_data_q;
  assign temp_valid  = temp_valid_q;
  assign err_nack    = err_nack_q;
  assign err_timeout = err_timeout_q;
  assign txn_count   = txn_count_q;

endmodule

// File: doc/i2c_temp_sequencer.md
Name: i2c_temp_sequencer

Overview:
- Transaction controller in front of a byte-level I2C engine. It polls the temperature sensor over a shared command/response interface.
- Each poll issues the full register-read sequence: START, address+W, pointer, repeated START, address+R, read MSB, read LSB, STOP.
- It latches the 16-bit result and flags protocol errors.
- Sits between the board clock domain and the I2C engine. Its result feeds the display/LED path in place of a raw engine byte.

Parameters:
- DEV_ADDR, 7'h4B, 7-bit sensor slave address.
- PTR_REG, 8'h00, sensor register pointer (temperature register).
- POLL_CYCLES, 50_000_000, clocks between automatic polls; legal range 2 to 2^32-1.
- TIMEOUT_CYCLES, 4096, maximum clocks from command accept to its response; minimum 2.

Ports:
- clk_50MHz  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  periodic polling enable.
- trigger  in  1  single-cycle request for an immediate poll.
- busy  out  1  high while a transaction is in progress.
- cmd_valid  out  1  command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_op  out  2  command code: 0 START, 1 STOP, 2 WRITE, 3 READ.
- cmd_wdata  out  8  byte for WRITE; 0 otherwise.
- cmd_last  out  1  for READ, 1 means master NACKs the byte; 0 otherwise.
- rsp_valid  in  1  single-cycle response, exactly one per accepted command.
- rsp_rdata  in  8  byte read; valid with a READ response.
- rsp_nack  in  1  slave NACK; meaningful with a WRITE response.
- temp_data  out  16  last good reading, {MSB, LSB}.
- temp_valid  out  1  one-cycle pulse when temp_data updates.
- err_nack  out  1  sticky: last transaction aborted on a slave NACK.
- err_timeout  out  1  sticky: last transaction aborted on timeout.
- txn_count  out  8  count of successful transactions, wraps.

Behaviour:
- Reset values: all outputs 0 and state IDLE. Poll timer loads POLL_CYCLES-1.
  - reset_n low forces cmd_valid low immediately and asynchronously.
  - Any in-flight transaction is abandoned. Engine recovery is out of scope.
- States: IDLE, ISSUE, WAIT_RSP, ABORT_ISSUE, ABORT_WAIT, DONE.
- Step sequence, indexed 0..7:
  - 0: START.
  - 1: WRITE {DEV_ADDR,0}.
  - 2: WRITE PTR_REG.
  - 3: START.
  - 4: WRITE {DEV_ADDR,1}.
  - 5: READ, cmd_last=0.
  - 6: READ, cmd_last=1.
  - 7: STOP.
- Poll timer:
  - Counts down only in IDLE with enable=1.
  - When it reaches 0 and the state is IDLE, launch a transaction and reload.
  - enable=0 holds the timer at its reload value.
- trigger=1 in IDLE launches immediately and reloads the timer. trigger is ignored when busy=1.
- Launch: IDLE -> ISSUE with step 0. busy rises on the same edge. cmd_valid is high in the cycle after the launch condition.
- ISSUE: cmd_valid=1 with op/data/last held stable. On cmd_valid&&cmd_ready, go to WAIT_RSP, drop cmd_valid and clear the timeout counter.
- WAIT_RSP on rsp_valid:
  - Step 5 captures rsp_rdata into the MSB holding register. Step 6 captures it into the LSB register.
  - WRITE step with rsp_nack=1: go to ABORT_ISSUE.
  - Step < 7: step+1, go to ISSUE. The next cmd_valid is high the cycle after the response.
  - Step 7: go to DONE.
  - rsp_nack is ignored on START, STOP and READ responses.
- DONE, one cycle:
  - temp_data <= {MSB,LSB} and temp_valid=1.
  - err_nack and err_timeout cleared; txn_count+1, wrapping 255->0.
  - Then IDLE with busy=0.
- ABORT_ISSUE: send STOP. ABORT_WAIT: on rsp_valid, set err_nack=1, go to IDLE. temp_data and txn_count are unchanged.
- Timeout:
  - Counter runs in WAIT_RSP and ABORT_WAIT only.
  - Reaching TIMEOUT_CYCLES sets err_timeout=1 and goes straight to IDLE with no STOP.
  - If rsp_valid arrives in the same cycle as the timeout limit, the response wins.
- rsp_valid outside WAIT_RSP/ABORT_WAIT is ignored.
- No timeout in ISSUE: the engine may stall cmd_ready indefinitely.
- enable dropping mid-transaction has no effect; the current transaction completes.
- Errors from a previous abort persist until the next successful DONE.

Test Plan:
- Successful poll:
  - Stimulus: POLL_CYCLES=20, enable=1, engine model always ready, responds 3 cycles after accept, returns 8'h1A then 8'h80.
  - Required: exactly 8 commands in the listed order, with cmd_wdata 8'h96, 8'h00, 8'h97 on the three WRITEs. temp_data=16'h1A80, a single temp_valid pulse, txn_count=1.
- Address NACK:
  - Stimulus: rsp_nack=1 on the step-1 response.
  - Required: the next command is STOP; err_nack=1 after its response; no temp_valid; temp_data and txn_count unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, engine never responds to the step-2 WRITE.
  - Required: err_timeout=1 exactly 8 cycles after accept; busy=0; no STOP issued. The next successful poll clears err_timeout.
- Trigger and stall:
  - Stimulus: enable=0, trigger pulse while IDLE, then cmd_ready held low for 50 cycles on step 3.
  - Required: cmd_valid is high the cycle after trigger and held stable through the stall. A second trigger pulse during busy starts no extra transaction.
- Reset mid-transaction:
  - Stimulus: assert reset_n low during step 5 WAIT_RSP.
  - Required: cmd_valid, busy and all outputs go to 0 asynchronously. After release, the first poll occurs POLL_CYCLES cycles later.
- Wrap:
  - Stimulus: 256 successful polls.
  - Required: txn_count returns to 0; temp_valid pulses 256 times.
